byte_unpacker: RTL and testbench
================================

BYTE_UNPACKER -- requirements
Module: byte_unpacker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the input/output word width in bits (a multiple of 8; W = DATA_WIDTH/8 bytes).
REQ-002 SHALL have parameter LEN_WIDTH, default 8, meaning the width of byte-length fields.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have in_data (input, DATA_WIDTH), in_valid (input, 1) and in_ready (output, 1): packed byte stream, first byte in the MS byte.
REQ-006 SHALL have req_len (input, LEN_WIDTH), req_valid (input, 1) and req_ready (output, 1): the number of bytes to extract per request.
REQ-007 SHALL have out_data (output, DATA_WIDTH), out_len (output, LEN_WIDTH), out_valid (output, 1) and out_ready (input, 1): the extracted token, left-aligned.
REQ-008 SHALL have flush (input, 1) to discard residual buffered bytes, and err (output, 1) as a sticky invalid-length flag.

Function
REQ-009 SHALL hold a 2*DATA_WIDTH-bit buffer: byte 0 (the oldest) in the MS byte, and a fill count of 0..2W bytes.
REQ-010 SHALL drive in_ready = (fill <= W), decoded from registered state only; an input transfer occurs on in_valid && in_ready.
REQ-011 SHALL append an accepted word at byte offset p: buffer |= ({in_data, DATA_WIDTH'b0} >> 8p), with fill += W.
- p = fill when no consume occurs in the same cycle.
- p = fill - req_len when a consume occurs in the same cycle.
REQ-012 SHALL define the output slot as free when (!out_valid || out_ready).
REQ-013 SHALL define a request as valid-length when 1 <= req_len <= W.
REQ-014 SHALL drive req_ready = slot_free && (fill >= req_len) for a valid-length request, and req_ready = 1 for an invalid-length request.
REQ-015 On a valid-length transfer (req_valid && req_ready), SHALL update the following registers:
- out_data = the top req_len bytes of the buffer, left-aligned, with the low bytes zero.
- out_len = req_len.
- out_valid = 1.
- buffer shifted left by 8*req_len.
- fill -= req_len.
REQ-016 Latency from request acceptance to out_valid SHALL be exactly 1 cycle; throughput SHALL be one token per cycle when data is available.
REQ-017 On an invalid-length transfer, SHALL set err = 1 (sticky until rst), leave buffer, fill and out_* unchanged, and produce no token.
REQ-018 SHALL clear out_valid on out_valid && out_ready when no new token is loaded in the same cycle.
REQ-019 While out_valid && !out_ready, out_data and out_len SHALL remain stable.
REQ-020 Simultaneous append and consume SHALL give new fill = fill - req_len + W; the extracted bytes SHALL come from the pre-append buffer only.
REQ-021 flush SHALL set fill = 0 and buffer = 0 next cycle and SHALL block both in and req transfers that cycle; out_* SHALL be unaffected.
REQ-022 fill SHALL never exceed 2W and never underflow; neither an append that overflows nor a consume larger than fill can occur.
REQ-023 Buffer bytes at positions >= fill SHALL always be zero.

Reset
REQ-024 rst SHALL set the following next cycle: buffer = 0, fill = 0, out_data = 0, out_len = 0, out_valid = 0, err = 0.
- Resulting outputs: in_ready = 1, and req_ready = 0 for any valid-length request.
REQ-025 rst SHALL take priority over flush and all handshakes, including mid-operation, and SHALL discard any pending token.

Verification
REQ-026 Bench SHALL cover reset and single-word extraction (DATA_WIDTH = 32):
- Reset -> out_valid = 0, in_ready = 1, err = 0.
- Push 0xAABBCCDD, then req 1 -> 0xAA000000, len 1.
- Then req 3 -> 0xBBCCDD00, len 3; fill returns to 0.
REQ-027 Bench SHALL cover extraction across words:
- Push 0x11223344 and 0x55667788.
- req 3 -> 0x11223300; req 3 -> 0x44556600; req 2 -> 0x77880000.
REQ-028 Bench SHALL cover backpressure with fill = 4 and out_ready = 0 after the first token:
- out_data is held stable and req_ready = 0.
- After out_ready = 1, the next token appears 1 cycle after acceptance.
REQ-029 Bench SHALL cover invalid lengths: req_len 0 or 5 -> req_ready = 1, err = 1, no out_valid, fill unchanged.
REQ-030 Bench SHALL cover a simultaneous append and req 2 at fill = 3 -> fill = 5 next cycle, with the byte order preserved in subsequent tokens.
REQ-031 Bench SHALL cover flush and reset:
- flush at fill = 6 -> fill = 0, in_ready = 1.
- rst asserted with out_valid = 1 -> out_valid = 0 next cycle.

Source files
------------

// File: rtl/byte_unpacker.sv
// Byte unpacker: buffers a packed, MS-byte-first word stream and hands out
// left-aligned tokens of 1..W bytes on request, with flush and a sticky length error.
module byte_unpacker #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic                  req_valid,
  output logic                  req_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [LEN_WIDTH-1:0]  out_len,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  flush,
  output logic                  err
);

  localparam int W      = DATA_WIDTH / 8;
  localparam int FILL_W = $clog2(2 * W + 1);
  // Common width for byte-count arithmetic so req_len and fill compare without truncation.
  localparam int CW     = (LEN_WIDTH > FILL_W) ? LEN_WIDTH : FILL_W;

  logic [2*DATA_WIDTH-1:0] bufReg;
  logic [2*DATA_WIDTH-1:0] bufNext;
  logic [2*DATA_WIDTH-1:0] shiftedBuf;
  logic [2*DATA_WIDTH-1:0] appendWord;
  logic [FILL_W-1:0]       fillReg;
  logic [FILL_W-1:0]       fillNext;
  logic [CW-1:0]           fillExt;
  logic [CW-1:0]           reqLenExt;
  logic [CW-1:0]           consumeLen;
  logic [CW-1:0]           appendPos;
  logic [DATA_WIDTH-1:0]   tokenMask;
  logic [DATA_WIDTH-1:0]   outDataReg;
  logic [LEN_WIDTH-1:0]    outLenReg;
  logic                    outValidReg;
  logic                    errReg;
  logic                    slotFree;
  logic                    lenValid;
  logic                    inFire;
  logic                    reqFire;
  logic                    consume;
  logic                    badReq;

  assign fillExt   = CW'(fillReg);
  assign reqLenExt = CW'(req_len);

  assign slotFree  = !outValidReg || out_ready;
  assign lenValid  = (reqLenExt != '0) && (reqLenExt <= CW'(W));

  assign in_ready  = (fillExt <= CW'(W));
  assign req_ready = lenValid ? (slotFree && (fillExt >= reqLenExt)) : 1'b1;

  // flush suppresses both handshakes for the cycle it is asserted.
  assign inFire    = in_valid && in_ready && !flush;
  assign reqFire   = req_valid && req_ready && !flush;
  assign consume   = reqFire && lenValid;
  assign badReq    = reqFire && !lenValid;

  // The appended word lands after the bytes that survive this cycle's consume.
  assign consumeLen = consume ? reqLenExt : '0;
  assign appendPos  = fillExt - consumeLen;
  assign shiftedBuf = bufReg << {consumeLen, 3'b000};
  assign appendWord = {in_data, {DATA_WIDTH{1'b0}}} >> {appendPos, 3'b000};
  assign bufNext    = inFire ? (shiftedBuf | appendWord) : shiftedBuf;
  assign fillNext   = FILL_W'(fillExt - consumeLen + (inFire ? CW'(W) : CW'(0)));

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : gMask
      assign tokenMask[DATA_WIDTH-1-8*gi -: 8] = (CW'(gi) < reqLenExt) ? 8'hFF : 8'h00;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      bufReg      <= '0;
      fillReg     <= '0;
      outDataReg  <= '0;
      outLenReg   <= '0;
      outValidReg <= 1'b0;
      errReg      <= 1'b0;
    end else begin
      if (flush) begin
        bufReg  <= '0;
        fillReg <= '0;
      end else begin
        bufReg  <= bufNext;
        fillReg <= fillNext;
      end
      if (consume) begin
        outDataReg  <= bufReg[2*DATA_WIDTH-1 -: DATA_WIDTH] & tokenMask;
        outLenReg   <= req_len;
        outValidReg <= 1'b1;
      end else if (out_ready) begin
        outValidReg <= 1'b0;
      end
      if (badReq) begin
        errReg <= 1'b1;
      end
    end
  end

  assign out_data  = outDataReg;
  assign out_len   = outLenReg;
  assign out_valid = outValidReg;
  assign err       = errReg;

endmodule

// File: tb/tb_byte_unpacker.sv
// Directed bench for byte_unpacker: requests push expected tokens into a
// scoreboard queue that a negedge monitor drains as tokens are handed off.
module tb_byte_unpacker;

  localparam int DW = 32;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [LW-1:0] req_len;
  logic          req_valid;
  logic          req_ready;
  logic [DW-1:0] out_data;
  logic [LW-1:0] out_len;
  logic          out_valid;
  logic          out_ready;
  logic          flush;
  logic          err;

  int nChecks = 0;
  int nFails  = 0;
  logic [DW+LW-1:0] sb[$];
  logic [DW+LW-1:0] expTok;

  always #5 clk = ~clk;

  byte_unpacker #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .req_len  (req_len),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .out_data (out_data),
    .out_len  (out_len),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .flush    (flush),
    .err      (err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic pushWord(input logic [DW-1:0] d);
    in_data  = d;
    in_valid = 1'b1;
    #1;
    for (int i = 0; i < 50 && !in_ready; i++) step();
    if (!in_ready) begin
      nChecks++;
      nFails++;
      $display("FAIL push timeout: in_ready got 0, expected 1 for word %h", d);
    end
    step();
    in_valid = 1'b0;
    $display("push %h", d);
  endtask

  task automatic request(input logic [LW-1:0] len, input logic [DW-1:0] exp);
    sb.push_back({exp, len});
    req_len   = len;
    req_valid = 1'b1;
    #1;
    for (int i = 0; i < 50 && !req_ready; i++) step();
    if (!req_ready) begin
      nChecks++;
      nFails++;
      $display("FAIL req timeout: req_ready got 0, expected 1 for len %0d", len);
    end
    step();
    req_valid = 1'b0;
    $display("req  len %0d", len);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      nChecks++;
      if (sb.size() == 0) begin
        nFails++;
        $display("FAIL token: got %h len %0d, expected no token", out_data, out_len);
      end else begin
        expTok = sb.pop_front();
        if ({out_data, out_len} !== expTok) begin
          nFails++;
          $display("FAIL token: got %h len %0d, expected %h len %0d",
                   out_data, out_len, expTok[DW+LW-1:LW], expTok[LW-1:0]);
        end else begin
          $display("tok  %h len %0d", out_data, out_len);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; req_len = '0; req_valid = 1'b0;
    out_ready = 1'b1; flush = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("reset out_valid", out_valid, 0);
    check("reset in_ready", in_ready, 1);
    check("reset err", err, 0);
    req_len = 8'd1; #1;
    check("reset req_ready", req_ready, 0);

    // Single word extraction
    pushWord(32'hAABBCCDD);
    request(8'd1, 32'hAA000000);
    request(8'd3, 32'hBBCCDD00);
    req_len = 8'd1; #1;
    check("empty req_ready", req_ready, 0);
    check("empty in_ready", in_ready, 1);

    // Across word boundaries
    pushWord(32'h11223344);
    pushWord(32'h55667788);
    check("full in_ready", in_ready, 0);
    request(8'd3, 32'h11223300);
    request(8'd3, 32'h44556600);
    request(8'd2, 32'h77880000);

    // Backpressure
    pushWord(32'h01020304);
    request(8'd2, 32'h01020000);
    out_ready = 1'b0;
    sb.push_back({32'h03040000, 8'd2});
    req_len = 8'd2; req_valid = 1'b1; #1;
    check("stall req_ready", req_ready, 0);
    step();
    check("stall out_valid", out_valid, 1);
    check("stall out_data", out_data, 32'h01020000);
    step();
    check("stall out_data held", out_data, 32'h01020000);
    check("stall out_len held", {24'd0, out_len}, 2);
    out_ready = 1'b1; #1;
    check("release req_ready", req_ready, 1);
    step();
    req_valid = 1'b0;
    check("release out_valid", out_valid, 1);
    check("release out_data", out_data, 32'h03040000);

    // Invalid lengths
    pushWord(32'h0A0B0C0D);
    req_len = 8'd0; req_valid = 1'b1; #1;
    check("len0 req_ready", req_ready, 1);
    step();
    req_valid = 1'b0;
    check("len0 err", err, 1);
    check("len0 out_valid", out_valid, 0);
    req_len = 8'd5; req_valid = 1'b1; #1;
    check("len5 req_ready", req_ready, 1);
    step();
    req_valid = 1'b0;
    check("len5 out_valid", out_valid, 0);
    req_len = 8'd4; #1;
    check("fill kept req_ready", req_ready, 1);
    check("fill kept in_ready", in_ready, 1);
    request(8'd4, 32'h0A0B0C0D);

    // Simultaneous append and consume at fill 3
    pushWord(32'h10203040);
    request(8'd1, 32'h10000000);
    sb.push_back({32'h20300000, 8'd2});
    in_data = 32'h50607080; in_valid = 1'b1;
    req_len = 8'd2; req_valid = 1'b1; #1;
    check("simul in_ready", in_ready, 1);
    check("simul req_ready", req_ready, 1);
    step();
    in_valid = 1'b0; req_valid = 1'b0;
    check("fill5 in_ready", in_ready, 0);
    request(8'd4, 32'h40506070);
    request(8'd1, 32'h80000000);

    // Flush at fill 6, with handshakes offered during the flush cycle
    pushWord(32'hA1A2A3A4);
    request(8'd2, 32'hA1A20000);
    pushWord(32'hB1B2B3B4);
    check("fill6 in_ready", in_ready, 0);
    flush = 1'b1;
    in_data = 32'hC1C2C3C4; in_valid = 1'b1;
    req_len = 8'd1; req_valid = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; req_valid = 1'b0;
    check("flush in_ready", in_ready, 1);
    check("flush out_valid", out_valid, 0);
    #1;
    check("flush req_ready", req_ready, 0);
    pushWord(32'hD1D2D3D4);
    request(8'd4, 32'hD1D2D3D4);

    // Reset with a pending token
    pushWord(32'hE1E2E3E4);
    out_ready = 1'b0;
    request(8'd1, 32'hE1000000);
    check("pending out_valid", out_valid, 1);
    check("err sticky", err, 1);
    rst = 1'b1;
    step();
    sb.delete();
    check("rst out_valid", out_valid, 0);
    check("rst in_ready", in_ready, 1);
    check("rst err", err, 0);
    req_len = 8'd1; #1;
    check("rst req_ready", req_ready, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    pushWord(32'hF0F1F2F3);
    request(8'd4, 32'hF0F1F2F3);

    repeat (3) step();
    check("scoreboard drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
